cache_controller: RTL and testbench
===================================

# cache_controller

Sequencing controller for the direct-mapped instruction/data cache path. It accepts one 15-bit word-address request at a time, resolves it as a hit or a miss against its tag/valid/line store, fetches a 128-bit block from main memory over a fixed-latency read on a miss, and returns the requested 32-bit word. It also maintains the hit and access counters for the hit-rate experiment, saturating at the access limit. It sits between the address generator (`array`) and `mainmem`.

## Interface
- `MEM_LATENCY`, 4: main-memory read latency in cycles; minimum 1.
- `ACCESS_LIMIT`, 8192: number of accesses after which the block stops accepting requests.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present; must hold `req_addr` stable until accepted.
- `req_ready`  out  1  high only in IDLE and while not `done`.
- `req_addr`  in  15  word address: tag=[14:12], index=[11:2], offset=[1:0].
- `resp_valid`  out  1  one-cycle pulse carrying the result.
- `resp_data`  out  32  requested word; held until the next response.
- `resp_hit`  out  1  1 = hit, 0 = miss/fill; held with `resp_data`.
- `mem_rd`  out  1  main-memory read strobe.
- `mem_addr`  out  13  block address {tag,index}; held throughout the read.
- `mem_data`  in  128  block from memory; word w = bits [32w+31:32w].
- `hit_count`  out  14  hits counted.
- `access_count`  out  14  accesses completed.
- `done`  out  1  `access_count == ACCESS_LIMIT`.

## Operation
- Storage: 1024 lines, each with a valid bit, a 3-bit tag, and 128 bits of data. Reset clears all valid bits. Tags and data are not reset.
- States:
  - IDLE: `req_ready` = !`done`. On `req_valid && req_ready`, latch `req_addr` and go to LOOKUP.
  - LOOKUP: hit when `valid[index] && tag_mem[index]==tag`.
    - On a hit, register word `offset` of the line into `resp_data`, set `resp_hit`=1, and go to RESP.
    - On a miss, load the wait counter with MEM_LATENCY-1 and go to MEM_WAIT.
  - MEM_WAIT: `mem_rd`=1 and `mem_addr`={tag,index}.
    - When the counter is 0, sample `mem_data` and write it to the line. Set the tag and set the valid bit. Register the word at `offset` into `resp_data`, set `resp_hit`=0, and go to RESP.
    - Otherwise, decrement the counter.
  - RESP: `resp_valid`=1. Increment `access_count`, and increment `hit_count` if `resp_hit`. Go to IDLE.
- Counters are 14-bit unsigned.
  - `access_count` never exceeds ACCESS_LIMIT.
  - `hit_count` ≤ `access_count` always.
- When `done`: `req_ready` stays 0, requests are ignored, counters freeze, and the cache contents are retained.
- `mem_rd`=0 and `mem_addr`=0 outside MEM_WAIT.
- A miss fill overwrites the line unconditionally. There is no write path and no dirty state.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_data`=0, `resp_hit`=0, `mem_rd`=0, `mem_addr`=0, both counters 0, `done`=0.
- Let T be the rising edge at which a request is accepted.
  - LOOKUP is the cycle after T.
  - Hit: `resp_valid` is high in the cycle after edge T+1.
  - Miss: `mem_rd` is high for exactly MEM_LATENCY cycles starting after edge T+1. `mem_data` is sampled at edge T+1+MEM_LATENCY. `resp_valid` is high in the following cycle.
- Counters update at the edge ending RESP. `done` rises at that same edge.
- The earliest next accept is the edge ending the IDLE cycle after RESP.
  - Back-to-back hits: one response every 3 cycles.
  - Back-to-back misses: one response every 3+MEM_LATENCY cycles.
- `req_valid` asserted in any non-IDLE state has no effect.
- Asserting `rst` mid-miss:
  - Outputs and state return to reset values immediately, without a clock.
  - The in-flight fill is discarded and no counter increments.
  - All lines become invalid.
- `mem_data` must be valid at the sampling edge only. It is not assumed stable earlier.

## Test plan
- Cold miss then hit, MEM_LATENCY=4, `mem_data` word w of block b = {b,w}:
  - Request 0x0005: `mem_rd` is high for 4 cycles with `mem_addr`=0x0001. `resp_data`=0x00000005 (block 0x0001, word 1), `resp_hit`=0, `resp_valid` 6 cycles after accept.
  - Request 0x0006: `resp_hit`=1, `resp_data`=0x00000006, `resp_valid` 2 cycles after accept, no `mem_rd`.
- Conflict eviction:
  - Request 0x0004 (miss), then 0x1004 (same index 1, tag 1; miss, `mem_addr`=0x0401), then 0x0004 again.
  - The third request misses. End state: `hit_count`=0, `access_count`=3.
- Sequential sweep 0..15:
  - Expect 4 misses, 12 hits, `hit_count`=12, `access_count`=16.
  - Hit responses arrive exactly 3 cycles apart.
- Saturation, with ACCESS_LIMIT=8 and requests held continuously:
  - After 8 responses, `done`=1 and `req_ready`=0.
  - A 9th `req_valid` yields no `resp_valid`, and `access_count` stays 8.
- Reset mid-miss:
  - Assert `rst` during cycle 2 of MEM_WAIT.
  - `mem_rd` falls asynchronously, counters are 0, and no `resp_valid` occurs.
  - Re-requesting the same address misses.
- Stall robustness: assert `req_valid` with a changed address during LOOKUP and MEM_WAIT. Neither the latched address nor the response changes.

Source files
------------

// File: rtl/cache_controller.sv
// Direct-mapped cache sequencer: tag/valid lookup, fixed-latency block fill on miss,
// single-word response, and saturating hit/access counters for the hit-rate experiment.
module cache_controller #(
   parameter int MEM_LATENCY  = 4,
   parameter int ACCESS_LIMIT = 8192
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [14:0]   req_addr,
   output logic          resp_valid,
   output logic [31:0]   resp_data,
   output logic          resp_hit,
   output logic          mem_rd,
   output logic [12:0]   mem_addr,
   input  logic [127:0]  mem_data,
   output logic [13:0]   hit_count,
   output logic [13:0]   access_count,
   output logic          done
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOOKUP = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   localparam int            CW        = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CW-1:0] WAIT_INIT = CW'(MEM_LATENCY - 1);
   localparam logic [13:0]   LIMIT     = 14'(ACCESS_LIMIT);

   logic [1:0]    state_q, state_d;
   logic [14:0]   addr_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          rhit_q, rhit_d;
   logic [13:0]   hits_q, acc_q;
   logic [1023:0] valid_q;

   // Tags and data are deliberately left unreset; the valid bits alone gate hits.
   logic [2:0]    tag_mem  [1024];
   logic [127:0]  data_mem [1024];

   logic [2:0]    tag;
   logic [9:0]    idx;
   logic [1:0]    off;
   logic          hit, fill, accept;

   function automatic logic [31:0] word_sel(input logic [127:0] line, input logic [1:0] o);
      return line[32*o +: 32];
   endfunction

   assign tag    = addr_q[14:12];
   assign idx    = addr_q[11:2];
   assign off    = addr_q[1:0];
   assign hit    = valid_q[idx] && (tag_mem[idx] == tag);
   assign fill   = (state_q == S_WAIT) && (cnt_q == '0);
   assign accept = req_valid && req_ready;

   assign done         = (acc_q == LIMIT);
   assign req_ready    = (state_q == S_IDLE) && !done;
   assign resp_valid   = (state_q == S_RESP);
   assign resp_data    = rdata_q;
   assign resp_hit     = rhit_q;
   assign mem_rd       = (state_q == S_WAIT);
   assign mem_addr     = mem_rd ? addr_q[14:2] : 13'd0;
   assign hit_count    = hits_q;
   assign access_count = acc_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      rhit_d  = rhit_q;
      case (state_q)
         S_IDLE:   if (accept) state_d = S_LOOKUP;
         S_LOOKUP: begin
            if (hit) begin
               rdata_d = word_sel(data_mem[idx], off);
               rhit_d  = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d   = WAIT_INIT;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               rdata_d = word_sel(mem_data, off);
               rhit_d  = 1'b0;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         rhit_q  <= 1'b0;
         hits_q  <= '0;
         acc_q   <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         rhit_q  <= rhit_d;
         if ((state_q == S_IDLE) && accept) addr_q <= req_addr;
         if (fill) valid_q[idx] <= 1'b1;
         // Counters only move on the edge that closes a response, and never past the limit.
         if ((state_q == S_RESP) && !done) begin
            acc_q <= acc_q + 14'd1;
            if (rhit_q) hits_q <= hits_q + 14'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fill) begin
         tag_mem[idx]  <= tag;
         data_mem[idx] <= mem_data;
      end
   end

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: per-cycle comparison against a transaction-level cache model,
// directed scenarios with literal expectations, and a randomized run to saturation.
module tb_cache_controller;
   localparam int L   = 4;
   localparam int LIM = 24;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic [14:0]   req_addr = '0;
   logic [127:0]  mem_data = '0;
   logic          req_ready, resp_valid, resp_hit, mem_rd, done;
   logic [31:0]   resp_data;
   logic [12:0]   mem_addr;
   logic [13:0]   hit_count, access_count;

   always #5 clk = ~clk;

   cache_controller #(.MEM_LATENCY(L), .ACCESS_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
      .hit_count(hit_count), .access_count(access_count), .done(done)
   );

   int checks = 0;
   int errors = 0;
   logic [16:0] salt = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory image: word w of block b is {salt, b, w}.
   function automatic logic [127:0] block(input logic [12:0] b);
      logic [127:0] r;
      for (int w = 0; w < 4; w++) r[32*w +: 32] = {salt, b, 2'(w)};
      return r;
   endfunction

   // Model: which block each line holds, plus one in-flight transaction timeline.
   logic        mvalid [1024];
   logic [2:0]  mtag   [1024];
   bit          active, miss, erdy, emrd, erv, hhit;
   int          n = 0, l0, rdue, macc, mhit, mrun, idx;
   logic [14:0] taddr;
   logic [31:0] edata, hdata;

   always @(negedge clk) begin
      n++;
      if (rst) begin
         active = 0; macc = 0; mhit = 0; hdata = '0; hhit = 0; mrun = 0;
         foreach (mvalid[i]) mvalid[i] = 1'b0;
      end else begin
         erdy = !active && (macc != LIM);
         emrd = active && miss && (n >= l0 + 1) && (n <= l0 + L);
         erv  = active && (n == rdue);
         if (erv) begin hdata = edata; hhit = !miss; end
         chk("req_ready", req_ready, erdy);
         chk("mem_rd", mem_rd, emrd);
         chk("mem_addr", mem_addr, emrd ? taddr[14:2] : 13'd0);
         chk("resp_valid", resp_valid, erv);
         chk("resp_data", resp_data, hdata);
         chk("resp_hit", resp_hit, hhit);
         chk("access_count", access_count, macc);
         chk("hit_count", hit_count, mhit);
         chk("done", done, macc == LIM);
         if (erv) begin
            macc++;
            if (!miss) mhit++;
            active = 0;
         end
         if (erdy && req_valid) begin
            idx    = int'(req_addr[11:2]);
            active = 1;
            l0     = n + 1;
            taddr  = req_addr;
            miss   = !(mvalid[idx] && mtag[idx] == req_addr[14:12]);
            mvalid[idx] = 1'b1;
            mtag[idx]   = req_addr[14:12];
            rdue   = l0 + 1 + (miss ? L : 0);
            edata  = {salt, req_addr};
         end
         // Memory responder: block is valid only across the sampling edge, garbage otherwise.
         if (mem_rd) mrun++; else mrun = 0;
         mem_data = (mrun == L) ? block(mem_addr) : {$urandom, $urandom, $urandom, $urandom};
      end
   end

   task automatic req(input logic [14:0] a, input bit stall, output int lat, output logic [31:0] d,
                      output logic h, output int mrd, output logic [12:0] ma);
      int guard = 0;
      @(posedge clk); #2;
      while (!req_ready && guard < 200) begin @(posedge clk); #2; guard++; end
      req_valid = 1'b1; req_addr = a;
      @(posedge clk); #2;
      req_valid = 1'b0;
      lat = 1; mrd = 0; ma = '0;
      while (!resp_valid && lat < 200) begin
         if (stall) begin req_valid = 1'b1; req_addr = 15'($urandom); end
         @(posedge clk); #2;
         lat++;
         if (mem_rd) begin mrd++; ma = mem_addr; end
      end
      req_valid = 1'b0;
      chk("resp_arrived", resp_valid, 1'b1);
      d = resp_data; h = resp_hit;
   endtask

   task automatic do_reset();
      @(posedge clk); #3;
      rst = 1'b1; #1;
      chk("rst_mem_rd", mem_rd, 1'b0);
      chk("rst_mem_addr", mem_addr, 13'd0);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_access", access_count, 14'd0);
      chk("rst_hits", hit_count, 14'd0);
      chk("rst_ready", req_ready, 1'b1);
      @(negedge clk); @(posedge clk); #2;
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat, mrd, misses, rvs;
      logic [31:0] d;
      logic h;
      logic [12:0] ma;
      time tprev;
      bit  hprev;

      #1;
      chk("init_resp_data", resp_data, 32'd0);
      chk("init_resp_hit", resp_hit, 1'b0);
      chk("init_done", done, 1'b0);
      chk("init_ready", req_ready, 1'b1);
      @(negedge clk); @(posedge clk); #2;
      rst = 1'b0;

      // Cold miss, then hit in the same block.
      req(15'h0005, 1'b0, lat, d, h, mrd, ma);
      chk("cold_data", d, 32'h5); chk("cold_hit", h, 1'b0); chk("cold_lat", lat, 6);
      chk("cold_mrd_cycles", mrd, 4); chk("cold_mem_addr", ma, 13'h0001);
      req(15'h0006, 1'b1, lat, d, h, mrd, ma);
      chk("hit_data", d, 32'h6); chk("hit_hit", h, 1'b1); chk("hit_lat", lat, 2);
      chk("hit_mrd_cycles", mrd, 0);

      // Conflict eviction on index 1.
      do_reset();
      req(15'h0004, 1'b1, lat, d, h, mrd, ma);
      chk("conf1_hit", h, 1'b0);
      req(15'h1004, 1'b1, lat, d, h, mrd, ma);
      chk("conf2_hit", h, 1'b0); chk("conf2_mem_addr", ma, 13'h0401); chk("conf2_data", d, 32'h1004);
      req(15'h0004, 1'b0, lat, d, h, mrd, ma);
      chk("conf3_hit", h, 1'b0); chk("conf3_data", d, 32'h0004);
      @(posedge clk); #2;
      chk("conf_hits", hit_count, 14'd0); chk("conf_access", access_count, 14'd3);

      // Sequential sweep; consecutive hits must be 3 cycles apart.
      do_reset();
      misses = 0; tprev = 0; hprev = 0;
      for (int a = 0; a < 16; a++) begin
         req(15'(a), 1'b0, lat, d, h, mrd, ma);
         chk("sweep_data", d, 32'(a));
         if (!h) misses++;
         if (h && hprev) chk("sweep_spacing", $time - tprev, 30);
         tprev = $time; hprev = h;
      end
      @(posedge clk); #2;
      chk("sweep_misses", misses, 4);
      chk("sweep_hits", hit_count, 14'd12); chk("sweep_access", access_count, 14'd16);

      // Saturation at LIM accesses.
      for (int a = 16; a < LIM; a++) req(15'(a), 1'b0, lat, d, h, mrd, ma);
      @(posedge clk); #2;
      chk("sat_done", done, 1'b1); chk("sat_ready", req_ready, 1'b0);
      chk("sat_access", access_count, 14'(LIM));
      rvs = 0;
      req_valid = 1'b1; req_addr = 15'h0007;
      for (int c = 0; c < 20; c++) begin @(posedge clk); #2; if (resp_valid) rvs++; end
      req_valid = 1'b0;
      chk("sat_no_resp", rvs, 0); chk("sat_access_frozen", access_count, 14'(LIM));

      // Reset during the second MEM_WAIT cycle.
      do_reset();
      @(posedge clk); #2;
      req_valid = 1'b1; req_addr = 15'h0040;
      @(posedge clk); #2;
      req_valid = 1'b0;
      @(posedge clk); #2;
      chk("midmiss_mem_rd_before", mem_rd, 1'b1);
      do_reset();
      req(15'h0040, 1'b0, lat, d, h, mrd, ma);
      chk("rereq_hit", h, 1'b0); chk("rereq_lat", lat, 6); chk("rereq_data", d, 32'h0040);

      // Randomized traffic to saturation with a fresh memory image.
      do_reset();
      salt = 17'($urandom);
      rvs = 0;
      for (int c = 0; c < 4000 && rvs < 20; c++) begin
         @(posedge clk); #2;
         req_valid = ($urandom_range(0, 3) != 0);
         req_addr  = {3'($urandom_range(0, 1)), 10'($urandom_range(0, 7)), 2'($urandom)};
         if (done) rvs++;
      end
      req_valid = 1'b0;
      @(posedge clk); #2;
      chk("rand_saturated", access_count, 14'(LIM));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
